// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for an 8-entry FIFO storage array.
// Protocol errors latch sticky flags and park the FSM in ERROR until reset.
module fifo_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [CNT_W-1:0]  af_thr,
  input  logic [CNT_W-1:0]  ae_thr,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [1:0]        state
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CountFull = CNT_W'(Depth);

  typedef enum logic [1:0] {
    StEmpty  = 2'b00,
    StActive = 2'b01,
    StFull   = 2'b10,
    StError  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  af_thr_q, af_thr_d;
  logic [CNT_W-1:0]  ae_thr_q, ae_thr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic ovf_evt;
  logic udf_evt;
  logic in_error;

  // Flags come straight from the registered occupancy.
  assign full         = (count_q == CountFull);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thr_q);
  assign almost_empty = (count_q <= ae_thr_q);

  assign in_error = (state_q == StError);

  // Strobes are masked while reset is held so the array is never touched.
  assign write = push & ~full  & ~in_error & reset;
  assign read  = pop  & ~empty & ~in_error & reset;

  assign ovf_evt = push & full;
  assign udf_evt = pop  & empty;

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign state     = state_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    af_thr_d    = af_thr_q;
    ae_thr_d    = ae_thr_q;
    overflow_d  = overflow_q | ovf_evt;
    underflow_d = underflow_q | udf_evt;

    if (!reset) begin
      state_d     = StEmpty;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      af_thr_d    = af_thr;
      ae_thr_d    = ae_thr;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (!in_error) begin
      if (write) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (read) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (write && !read) begin
        count_d = count_q + 1'b1;
      end else if (read && !write) begin
        count_d = count_q - 1'b1;
      end

      // An error outranks any occupancy-driven transition.
      if (ovf_evt || udf_evt) begin
        state_d = StError;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (write) begin
              state_d = StActive;
            end
          end
          StActive: begin
            if (count_d == CountFull) begin
              state_d = StFull;
            end else if (count_d == '0) begin
              state_d = StEmpty;
            end
          end
          StFull: begin
            if (read) begin
              state_d = StActive;
            end
          end
          default: state_d = StError;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    af_thr_q    <= af_thr_d;
    ae_thr_q    <= ae_thr_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl: reset, fill, drain, concurrent
// traffic, overflow and underflow with recovery through reset.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [3:0] af_thr;
  logic [3:0] ae_thr;
  logic       write;
  logic       read;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic [1:0] state;

  int checks;
  int failures;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    af_thr   = 4'd6;
    ae_thr   = 4'd2;

    // Reset: two cycles, second with push held to confirm strobes are masked.
    tick();
    push = 1'b1;
    #1;
    check("reset_write_masked", 32'(write), 32'd0);
    tick();
    push   = 1'b0;
    reset  = 1'b1;
    af_thr = 4'd0;  // thresholds must stay frozen at 6/2
    ae_thr = 4'd8;
    #1;
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    // Fill: 8 pushes.
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      #1;
      check("fill_write", 32'(write), 32'd1);
      check("fill_wr_ptr", 32'(wr_ptr), 32'(i));
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 6));
      check("fill_almost_empty", 32'(almost_empty), 32'((i + 1) <= 2));
    end
    push = 1'b0;
    #1;
    check("fill_wr_wrap", 32'(wr_ptr), 32'd0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_state", 32'(state), 32'd2);

    // Drain with wrap: 8 pops.
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      #1;
      check("drain_read", 32'(read), 32'd1);
      check("drain_rd_ptr", 32'(rd_ptr), 32'(i));
      tick();
      check("drain_count", 32'(count), 32'(7 - i));
    end
    pop = 1'b0;
    #1;
    check("drain_rd_wrap", 32'(rd_ptr), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_state", 32'(state), 32'd0);
    check("drain_overflow", 32'(overflow), 32'd0);
    check("drain_underflow", 32'(underflow), 32'd0);

    // Concurrent: bring count to 4, then push+pop for 5 cycles.
    push = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("conc_write", 32'(write), 32'd1);
      check("conc_read", 32'(read), 32'd1);
      tick();
    end
    push = 1'b0;
    pop  = 1'b0;
    #1;
    check("conc_count", 32'(count), 32'd4);
    check("conc_wr_ptr", 32'(wr_ptr), 32'd1);
    check("conc_rd_ptr", 32'(rd_ptr), 32'd5);
    check("conc_state", 32'(state), 32'd1);

    // Overflow: fill to 8, then push+pop together.
    push = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("ovf_pre_full", 32'(full), 32'd1);
    check("ovf_pre_state", 32'(state), 32'd2);
    pop = 1'b1;
    #1;
    check("ovf_read", 32'(read), 32'd1);
    check("ovf_write", 32'(write), 32'd0);
    tick();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_state", 32'(state), 32'd3);
    check("ovf_count", 32'(count), 32'd7);
    check("ovf_rd_ptr", 32'(rd_ptr), 32'd6);
    #1;
    check("err_write", 32'(write), 32'd0);
    check("err_read", 32'(read), 32'd0);
    tick();
    check("err_count_frozen", 32'(count), 32'd7);
    check("err_wr_frozen", 32'(wr_ptr), 32'd5);
    check("err_rd_frozen", 32'(rd_ptr), 32'd6);
    check("err_state_held", 32'(state), 32'd3);

    // Reset out of ERROR.
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rec_state", 32'(state), 32'd0);
    check("rec_overflow", 32'(overflow), 32'd0);
    check("rec_count", 32'(count), 32'd0);

    // Underflow from empty.
    pop = 1'b1;
    #1;
    check("udf_read", 32'(read), 32'd0);
    tick();
    pop = 1'b0;
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_state", 32'(state), 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("udf_rec_flag", 32'(underflow), 32'd0);
    check("udf_rec_state", 32'(state), 32'd0);

    // Push+pop on empty: push serviced, pop rejected, underflow raised.
    push = 1'b1;
    pop  = 1'b1;
    #1;
    check("emp_pp_write", 32'(write), 32'd1);
    check("emp_pp_read", 32'(read), 32'd0);
    tick();
    push = 1'b0;
    pop  = 1'b0;
    check("emp_pp_count", 32'(count), 32'd1);
    check("emp_pp_underflow", 32'(underflow), 32'd1);
    check("emp_pp_state", 32'(state), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the 8-entry × 12-bit FIFO storage array. Sits directly upstream of the storage array: it converts producer `push` and consumer `pop` requests into the array's `write`/`read` strobes and `wr_ptr`/`rd_ptr` addresses. It also tracks occupancy, raises full/empty/almost flags and latches protocol errors into a terminal ERROR state.

## Interface
Parameters
- `ADDR_W`, 3, pointer width; depth = 2^ADDR_W (8).
- `CNT_W`, ADDR_W+1 (4), occupancy/threshold width, range 0..8.

Ports (name, direction, width, meaning)
- `clk`, in, 1, clock; all state updates on the rising edge.
- `reset`, in, 1, synchronous, active-low.
- `push`, in, 1, producer requests a write this cycle.
- `pop`, in, 1, consumer requests a read this cycle.
- `af_thr`, in, CNT_W, almost-full threshold; sampled only while `reset`=0.
- `ae_thr`, in, CNT_W, almost-empty threshold; sampled only while `reset`=0.
- `write`, out, 1, write strobe to the storage array.
- `read`, out, 1, read strobe to the storage array.
- `wr_ptr`, out, ADDR_W, write address.
- `rd_ptr`, out, ADDR_W, read address.
- `count`, out, CNT_W, current occupancy.
- `full`, `empty`, `almost_full`, `almost_empty`, out, 1 each, status flags.
- `overflow`, `underflow`, out, 1 each, sticky error flags.
- `state`, out, 2, FSM state: EMPTY=00, ACTIVE=01, FULL=10, ERROR=11.

## Operation
- **Reset** (`reset`=0 at a rising edge):
  - `wr_ptr`=`rd_ptr`=0, `count`=0, `state`=EMPTY.
  - `overflow`=`underflow`=0.
  - Thresholds register `af_thr`/`ae_thr` on every reset cycle. Those values are frozen after `reset` returns to 1.
  - Outputs during and after reset: `write`=`read`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full` = (af_thr_reg==0).
- **Strobes** (combinational):
  - `write` = `push` & ~`full` & (`state`≠ERROR).
  - `read` = `pop` & ~`empty` & (`state`≠ERROR).
- **Pointers**:
  - `wr_ptr` increments mod 8 on each `write`; `rd_ptr` increments mod 8 on each `read`. Wrap 7→0 is silent.
- **Count**:
  - +1 on `write` only, −1 on `read` only, unchanged when both or neither fire.
- **Flags** (combinational from registered `count`):
  - `full` = (count==8), `empty` = (count==0).
  - `almost_full` = (count ≥ af_thr_reg), `almost_empty` = (count ≤ ae_thr_reg).
- **Simultaneous push+pop**:
  - ACTIVE: both serviced, count unchanged.
  - FULL: pop serviced, push rejected, overflow raised.
  - EMPTY: push serviced, pop rejected, underflow raised. There is no pass-through.
- **Errors**:
  - `push`=1 while `full` sets `overflow`; `pop`=1 while `empty` sets `underflow`.
  - Either error moves `state` to ERROR.
- **FSM transitions** (evaluated at the edge):
  - EMPTY→ACTIVE on a write.
  - ACTIVE→FULL when the next count is 8.
  - ACTIVE→EMPTY when the next count is 0.
  - FULL→ACTIVE on a read.
  - Any state→ERROR on an error condition; the error takes priority over the occupancy transition.
  - ERROR is left only via reset. In ERROR, pointers and count are frozen and strobes are held at 0.

## Timing
- `write`/`read`/`wr_ptr`/`rd_ptr` are valid in the same cycle as the request. The array writes at the closing edge and returns read data combinationally in the same cycle.
- Pointer, count and state updates are visible one cycle after the servicing edge. Flags follow `count` with no extra delay.
- `overflow`/`underflow`/ERROR assert one cycle after the offending request cycle.
- Reset mid-operation: the next edge with `reset`=0 clears everything regardless of `state`, including ERROR. Stored array contents are the array's responsibility.

## Test plan
- **Reset**: reset=0 with af_thr=6, ae_thr=2 for 2 cycles, then reset=1 → ptrs 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, state=00.
- **Fill**: 8 consecutive pushes → write=1 each cycle, wr_ptr 0..7 then 0, count 8, full=1, state=10. almost_full rises on the cycle count reaches 6; almost_empty falls when count reaches 3.
- **Drain with wrap**: after fill, 8 pops → read=1, rd_ptr 0..7 then 0, count 0, empty=1, state=00, no error flags.
- **Concurrent**: count=4, then push+pop for 5 cycles → count stays 4, both pointers advance 5 (wrap across 7→0), state stays 01.
- **Overflow**: from full, push+pop in one cycle → read=1, write=0, next cycle overflow=1, state=11. Further pushes and pops produce write=read=0 and a frozen count.
- **Underflow recovery**: from empty, pop=1 → read=0, underflow=1, state=11. Then reset=0 for one cycle → underflow=0, state=00.
